multi_vc_input_buffer: RTL and testbench
========================================

MULTI_VC_INPUT_BUFFER -- requirements
Module: multi_vc_input_buffer

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 8, flit slots per virtual channel; power of two, at least 2.
REQ-002 SHALL have parameter VC_NUM, default 2, number of virtual channels; VC_SIZE = $clog2(VC_NUM) as in noc_params.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port data_i  input  flit_t  incoming flit; data_i.vc_id selects the target VC.
REQ-006 SHALL have port valid_i  input  1  write strobe for data_i.
REQ-007 SHALL have port read_i  input  VC_NUM  one-hot read grant from switch allocation.
REQ-008 SHALL have port out_port_i  input  VC_NUM x port_t  route computed externally from each data_o head.
REQ-009 SHALL have port vc_valid_i  input  VC_NUM  downstream VC granted, per VC.
REQ-010 SHALL have port vc_new_i  input  VC_NUM x VC_SIZE  granted downstream VC id.
REQ-011 SHALL have port data_o  output  VC_NUM x flit_t  front flit per VC, vc_id replaced by the latched downstream VC.
REQ-012 SHALL have ports is_full_o / is_empty_o  output  VC_NUM each  per-VC occupancy flags.
REQ-013 SHALL have port out_port_o  output  VC_NUM x port_t  latched output port per VC.
REQ-014 SHALL have ports va_request_o / sa_request_o  output  VC_NUM each  allocation requests.
REQ-015 SHALL have port error_o  output  VC_NUM  sticky protocol-violation flag per VC.

Function
REQ-016 Each VC SHALL own an independent circular FIFO: write pointer, read pointer, occupancy counter of width $clog2(BUFFER_SIZE+1); pointers wrap from BUFFER_SIZE-1 to 0.
REQ-017 data_o[v] SHALL be combinational from the slot at read pointer v: flit_label and data from the buffer, vc_id = downstream_vc[v]; contents undefined when is_empty_o[v]=1.
REQ-018 A write SHALL be accepted when valid_i=1 and the selected VC is not full at the clock edge; the flit appears at data_o one cycle later if the VC was empty.
REQ-019 Write to a full VC SHALL be dropped and SHALL set error_o[v], even when read_i[v]=1 in the same cycle.
REQ-020 A read SHALL be accepted only when read_i[v]=1, VC v in state SA and not empty; otherwise the read is ignored and error_o[v] is set.
REQ-021 Simultaneous accepted read and write on one VC SHALL leave occupancy unchanged and advance both pointers.
REQ-022 is_full_o[v] = (count == BUFFER_SIZE), is_empty_o[v] = (count == 0), both derived from registered count.
REQ-023 Per-VC FSM SHALL have states IDLE, VA, SA.
REQ-024 IDLE->VA when VC non-empty and front flit_label is HEAD or HEADTAIL; out_port_o[v] <= out_port_i[v] on that edge.
REQ-025 IDLE with non-empty VC and front not HEAD/HEADTAIL SHALL set error_o[v] and discard that front flit (pointer advance).
REQ-026 VA->SA when vc_valid_i[v]=1; downstream_vc[v] <= vc_new_i[v] on that edge; vc_valid_i[v] in IDLE or SA SHALL be ignored.
REQ-027 SA->IDLE on the edge an accepted read removes a TAIL or HEADTAIL flit; a head queued behind it reaches VA one cycle later (REQ-024).
REQ-028 va_request_o[v] = (state==VA); sa_request_o[v] = (state==SA) and not empty; both from registered state.
REQ-029 Minimum latency head write to va_request_o: 2 cycles; single-flit HEADTAIL packet occupies SA for exactly one accepted read.
REQ-030 Multiple queued packets per VC SHALL be permitted; no flits of a following packet are read before the preceding tail.

Reset
REQ-031 On rst=0, asynchronously: all pointers and counts 0, all states IDLE, out_port_o LOCAL, downstream_vc 0, is_empty_o all 1, is_full_o all 0, error_o all 0, va/sa requests 0.
REQ-032 Reset mid-packet SHALL discard all buffered flits; no flit written before reset is ever presented afterwards.
REQ-033 After rst returns to 1, a write on the first rising edge SHALL be accepted.

Verification
REQ-034 HEAD,BODY,TAIL to VC1 at t0..t2, out_port_i[1]=EAST, vc_valid_i[1]=1 with vc_new_i=0 at t3 -> va_request_o[1]=1 at t2, SA at t4, three reads give data_o vc_id=0, IDLE after tail.
REQ-035 Fill VC0 with 8 flits then one more write -> is_full_o[0]=1, 9th write dropped, error_o[0]=1, VC1 unaffected.
REQ-036 Two HEADTAIL packets back-to-back on VC0 -> two IDLE->VA->SA cycles, out_port_o relatched per packet.
REQ-037 Full VC with simultaneous read and write -> write dropped, count 7, error set; at count 4 simultaneous read/write -> count stays 4, pointers wrap correctly over 20 cycles.
REQ-038 Assert rst=0 mid-packet while in SA -> immediately empty, IDLE, out_port_o LOCAL; subsequent new packet processed normally.

Source files
------------

// File: rtl/multi_vc_input_buffer_if.sv
// rtl/multi_vc_input_buffer_if.sv - flit/port types and the input buffer port bundle
//
// noc_params holds the flit format shared by router blocks: a 2-bit label,
// a vc_id wide enough for VC_NUM channels and a 16-bit payload.
//
// multi_vc_input_buffer_if groups every non-clock/reset signal of the buffer.
//   master : upstream link + allocators (drive data_i/valid_i/read_i/route/VA grant)
//   slave  : the input buffer (drives per-VC data, flags, requests, error)
package noc_params;
  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int DATA_W  = 16;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_W-1:0]    data;
  } flit_t;
endpackage

interface multi_vc_input_buffer_if #(
  parameter int VC_NUM = noc_params::VC_NUM
);
  localparam int VC_SIZE = noc_params::VC_SIZE;

  noc_params::flit_t  data_i;
  logic               valid_i;
  logic [VC_NUM-1:0]  read_i;
  noc_params::port_t  out_port_i [VC_NUM];
  logic [VC_NUM-1:0]  vc_valid_i;
  logic [VC_SIZE-1:0] vc_new_i   [VC_NUM];

  noc_params::flit_t  data_o     [VC_NUM];
  logic [VC_NUM-1:0]  is_full_o;
  logic [VC_NUM-1:0]  is_empty_o;
  noc_params::port_t  out_port_o [VC_NUM];
  logic [VC_NUM-1:0]  va_request_o;
  logic [VC_NUM-1:0]  sa_request_o;
  logic [VC_NUM-1:0]  error_o;

  modport master (
    output data_i, valid_i, read_i, out_port_i, vc_valid_i, vc_new_i,
    input  data_o, is_full_o, is_empty_o, out_port_o, va_request_o, sa_request_o, error_o
  );

  modport slave (
    input  data_i, valid_i, read_i, out_port_i, vc_valid_i, vc_new_i,
    output data_o, is_full_o, is_empty_o, out_port_o, va_request_o, sa_request_o, error_o
  );
endinterface

// File: rtl/multi_vc_input_buffer.sv
// rtl/multi_vc_input_buffer.sv - router input port buffer with one FIFO and VA/SA FSM per VC
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : multi_vc_input_buffer_if.slave
//          data_i/valid_i write a flit into VC data_i.vc_id; read_i is the one-hot
//          switch grant; out_port_i/vc_valid_i/vc_new_i are route and VA results.
//          data_o is the front flit per VC with vc_id rewritten to the granted
//          downstream VC; flags, requests and a sticky error flag per VC.
// VC_NUM must match noc_params::VC_NUM, which sizes the flit vc_id field.
module multi_vc_input_buffer #(
  parameter int BUFFER_SIZE = 8,
  parameter int VC_NUM      = noc_params::VC_NUM
) (
  input logic                     clk,
  input logic                     rst,
  multi_vc_input_buffer_if.slave  bus
);
  typedef noc_params::port_t       port_t;
  typedef noc_params::flit_label_t flit_label_t;

  localparam int VC_SIZE = noc_params::VC_SIZE;
  localparam int DATA_W  = noc_params::DATA_W;
  localparam int PTR_W   = $clog2(BUFFER_SIZE);
  localparam int CNT_W   = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [1:0] {IDLE, VA, SA} state_t;

  flit_label_t        label_mem [VC_NUM][BUFFER_SIZE];
  logic [DATA_W-1:0]  data_mem  [VC_NUM][BUFFER_SIZE];

  logic [PTR_W-1:0]   wr_ptr        [VC_NUM];
  logic [PTR_W-1:0]   rd_ptr        [VC_NUM];
  logic [CNT_W-1:0]   count         [VC_NUM];
  state_t             state         [VC_NUM];
  logic [VC_SIZE-1:0] downstream_vc [VC_NUM];
  port_t              out_port_q    [VC_NUM];
  logic [VC_NUM-1:0]  error_q;

  logic [VC_NUM-1:0]  full, empty, is_head, wr_en, rd_ok, discard, pop, err_set;
  flit_label_t        front_label [VC_NUM];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      full[v]        = (count[v] == CNT_W'(BUFFER_SIZE));
      empty[v]       = (count[v] == '0);
      front_label[v] = label_mem[v][rd_ptr[v]];
      is_head[v]     = (front_label[v] == noc_params::HEAD) ||
                       (front_label[v] == noc_params::HEADTAIL);
      wr_en[v]       = bus.valid_i && (bus.data_i.vc_id == VC_SIZE'(v)) && !full[v];
      rd_ok[v]       = bus.read_i[v] && (state[v] == SA) && !empty[v];
      // A non-head flit at the front of an idle VC can never be routed; drop it.
      discard[v]     = (state[v] == IDLE) && !empty[v] && !is_head[v];
      pop[v]         = rd_ok[v] || discard[v];
      // Full check uses the pre-edge count, so a same-cycle read does not make room.
      err_set[v]     = (bus.valid_i && (bus.data_i.vc_id == VC_SIZE'(v)) && full[v]) ||
                       (bus.read_i[v] && !rd_ok[v]) || discard[v];
    end
  end

  // Flit storage needs no reset: count gates every use of its contents.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_en[v]) begin
        label_mem[v][wr_ptr[v]] <= bus.data_i.flit_label;
        data_mem[v][wr_ptr[v]]  <= bus.data_i.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v]        <= '0;
        rd_ptr[v]        <= '0;
        count[v]         <= '0;
        state[v]         <= IDLE;
        downstream_vc[v] <= '0;
        out_port_q[v]    <= noc_params::LOCAL;
      end
      error_q <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (wr_en[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
        if (pop[v])   rd_ptr[v] <= ptr_inc(rd_ptr[v]);
        case ({wr_en[v], pop[v]})
          2'b10:   count[v] <= count[v] + CNT_W'(1);
          2'b01:   count[v] <= count[v] - CNT_W'(1);
          default: count[v] <= count[v];
        endcase
        if (err_set[v]) error_q[v] <= 1'b1;

        case (state[v])
          IDLE: if (!empty[v] && is_head[v]) begin
            state[v]      <= VA;
            out_port_q[v] <= bus.out_port_i[v];
          end
          VA: if (bus.vc_valid_i[v]) begin
            state[v]         <= SA;
            downstream_vc[v] <= bus.vc_new_i[v];
          end
          SA: if (rd_ok[v] && ((front_label[v] == noc_params::TAIL) ||
                               (front_label[v] == noc_params::HEADTAIL))) begin
            state[v] <= IDLE;
          end
          default: state[v] <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < VC_NUM; g++) begin : g_out
    assign bus.data_o[g]       = {label_mem[g][rd_ptr[g]], downstream_vc[g], data_mem[g][rd_ptr[g]]};
    assign bus.is_full_o[g]    = full[g];
    assign bus.is_empty_o[g]   = empty[g];
    assign bus.out_port_o[g]   = out_port_q[g];
    assign bus.va_request_o[g] = (state[g] == VA);
    assign bus.sa_request_o[g] = (state[g] == SA) && !empty[g];
    assign bus.error_o[g]      = error_q[g];
  end
endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// tb/tb_multi_vc_input_buffer.sv - randomized and directed bench with per-VC queue reference model
module tb_multi_vc_input_buffer;
  import noc_params::*;

  localparam int BS = 8;
  localparam int NV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_vc_input_buffer_if #(.VC_NUM(NV)) bus();
  multi_vc_input_buffer #(.BUFFER_SIZE(BS), .VC_NUM(NV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue per VC plus the packet phase it is in
  // (0 waiting for a head, 1 waiting for a downstream VC, 2 sending).
  typedef struct packed {
    flit_label_t  lab;
    logic [15:0]  data;
  } mflit_t;

  mflit_t             mq [NV][$];
  int                 phase [NV];
  port_t              m_port [NV];
  logic [VC_SIZE-1:0] m_dvc [NV];
  bit                 m_err [NV];
  bit                 in_pkt [NV];

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      phase[v]  = 0;
      m_port[v] = LOCAL;
      m_dvc[v]  = '0;
      m_err[v]  = 1'b0;
      in_pkt[v] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int v = 0; v < NV; v++) begin
      bit     was_empty, was_full, pop, headlike, taillike;
      mflit_t f;
      was_empty = (mq[v].size() == 0);
      was_full  = (mq[v].size() == BS);
      pop       = 1'b0;
      f         = '0;
      if (!was_empty) f = mq[v][0];
      headlike = (f.lab == HEAD) || (f.lab == HEADTAIL);
      taillike = (f.lab == TAIL) || (f.lab == HEADTAIL);
      if (bus.read_i[v]) begin
        if (phase[v] == 2 && !was_empty) pop = 1'b1;
        else m_err[v] = 1'b1;
      end
      if (phase[v] == 0 && !was_empty && !headlike) begin
        pop = 1'b1;
        m_err[v] = 1'b1;
      end
      if (phase[v] == 0 && !was_empty && headlike) begin
        phase[v]  = 1;
        m_port[v] = bus.out_port_i[v];
      end else if (phase[v] == 1 && bus.vc_valid_i[v]) begin
        phase[v] = 2;
        m_dvc[v] = bus.vc_new_i[v];
      end else if (phase[v] == 2 && pop && taillike) begin
        phase[v] = 0;
      end
      if (pop) void'(mq[v].pop_front());
      if (bus.valid_i && int'(bus.data_i.vc_id) == v) begin
        if (was_full) m_err[v] = 1'b1;
        else mq[v].push_back({bus.data_i.flit_label, bus.data_i.data});
      end
    end
  endfunction

  task automatic check_all();
    for (int v = 0; v < NV; v++) begin
      int n;
      n = mq[v].size();
      check_eq($sformatf("is_full[%0d]", v),    32'(bus.is_full_o[v]),    32'(n == BS));
      check_eq($sformatf("is_empty[%0d]", v),   32'(bus.is_empty_o[v]),   32'(n == 0));
      check_eq($sformatf("va_request[%0d]", v), 32'(bus.va_request_o[v]), 32'(phase[v] == 1));
      check_eq($sformatf("sa_request[%0d]", v), 32'(bus.sa_request_o[v]), 32'(phase[v] == 2 && n > 0));
      check_eq($sformatf("out_port[%0d]", v),   32'(bus.out_port_o[v]),   32'(m_port[v]));
      check_eq($sformatf("error[%0d]", v),      32'(bus.error_o[v]),      32'(m_err[v]));
      if (n > 0) begin
        check_eq($sformatf("front_label[%0d]", v), 32'(bus.data_o[v].flit_label), 32'(mq[v][0].lab));
        check_eq($sformatf("front_data[%0d]", v),  32'(bus.data_o[v].data),       32'(mq[v][0].data));
        check_eq($sformatf("front_vc[%0d]", v),    32'(bus.data_o[v].vc_id),      32'(m_dvc[v]));
      end
    end
  endtask

  task automatic idle();
    bus.valid_i    = 1'b0;
    bus.data_i     = '0;
    bus.read_i     = '0;
    bus.vc_valid_i = '0;
  endtask

  task automatic wr(input int vc, input flit_label_t lab, input logic [15:0] d);
    bus.valid_i           = 1'b1;
    bus.data_i.flit_label = lab;
    bus.data_i.vc_id      = VC_SIZE'(vc);
    bus.data_i.data       = d;
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    int va_cnt;
    logic prev_va;
    idle();
    for (int v = 0; v < NV; v++) begin
      bus.out_port_i[v] = LOCAL;
      bus.vc_new_i[v]   = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // HEAD/BODY/TAIL on VC1, route EAST, downstream VC 0.
    bus.out_port_i[1] = EAST;
    wr(1, HEAD, 16'h1111); step();
    wr(1, BODY, 16'h2222); step();
    check_eq("va_at_t2", 32'(bus.va_request_o[1]), 32'd1);
    wr(1, TAIL, 16'h3333); step();
    idle(); bus.vc_valid_i[1] = 1'b1; bus.vc_new_i[1] = '0; step();
    bus.vc_valid_i[1] = 1'b0;
    check_eq("sa_at_t4", 32'(bus.sa_request_o[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("pkt_vc_id", 32'(bus.data_o[1].vc_id), 32'd0);
      bus.read_i = 2'b10; step();
    end
    bus.read_i = '0;
    check_eq("pkt_done_idle", 32'({bus.va_request_o[1], bus.sa_request_o[1]}), 32'd0);
    check_eq("pkt_port_east", 32'(bus.out_port_o[1]), 32'(EAST));

    // Fill VC0, then overflow it.
    do_reset();
    wr(0, HEAD, 16'h0100); step();
    for (int i = 1; i < BS; i++) begin wr(0, BODY, 16'(16'h0100 + i)); step(); end
    check_eq("full_vc0", 32'(bus.is_full_o[0]), 32'd1);
    wr(0, BODY, 16'hdead); step();
    check_eq("ovf_err0", 32'(bus.error_o[0]), 32'd1);
    check_eq("ovf_err1", 32'(bus.error_o[1]), 32'd0);
    check_eq("ovf_vc1_empty", 32'(bus.is_empty_o[1]), 32'd1);

    // Full VC with read+write: write dropped; then drain to 4 and stream through the wrap.
    idle(); bus.vc_valid_i[0] = 1'b1; step();
    bus.vc_valid_i[0] = 1'b0;
    bus.read_i = 2'b01; wr(0, BODY, 16'hbeef); step();
    check_eq("rw_full_dropped", 32'(bus.is_full_o[0]), 32'd0);
    idle(); bus.read_i = 2'b01;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 20; i++) begin
      bus.read_i = 2'b01; wr(0, BODY, 16'(16'h0200 + i)); step();
    end
    idle();

    // Reset while VC0 is in SA with flits buffered.
    do_reset();
    check_eq("rst_empty0", 32'(bus.is_empty_o[0]), 32'd1);
    check_eq("rst_va0", 32'(bus.va_request_o[0]), 32'd0);
    check_eq("rst_port0", 32'(bus.out_port_o[0]), 32'(LOCAL));

    // Two HEADTAIL packets back to back on VC0, route changing every cycle.
    wr(0, HEADTAIL, 16'haaaa); step();
    wr(0, HEADTAIL, 16'hbbbb); step();
    idle();
    va_cnt  = (bus.va_request_o[0]) ? 1 : 0;
    prev_va = bus.va_request_o[0];
    for (int c = 0; c < 14; c++) begin
      bus.vc_valid_i[0] = 1'b1;
      bus.vc_new_i[0]   = VC_SIZE'(c);
      bus.out_port_i[0] = port_t'(c % 5);
      bus.read_i        = (phase[0] == 2 && mq[0].size() > 0) ? 2'b01 : 2'b00;
      step();
      if (bus.va_request_o[0] && !prev_va) va_cnt++;
      prev_va = bus.va_request_o[0];
    end
    check_eq("two_ht_va_entries", 32'(va_cnt), 32'd2);
    check_eq("two_ht_drained", 32'(bus.is_empty_o[0]), 32'd1);
    idle();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int vc, r;
      flit_label_t lab;
      if ($urandom_range(0, 299) == 0) do_reset();
      idle();
      if ($urandom_range(0, 9) < 6) begin
        vc = $urandom_range(0, NV - 1);
        if ($urandom_range(0, 49) == 0) lab = flit_label_t'($urandom_range(0, 3));
        else if (!in_pkt[vc]) begin
          lab = ($urandom_range(0, 9) < 3) ? HEADTAIL : HEAD;
          in_pkt[vc] = (lab == HEAD);
        end else begin
          lab = ($urandom_range(0, 9) < 3) ? TAIL : BODY;
          in_pkt[vc] = (lab == BODY);
        end
        wr(vc, lab, 16'($urandom));
      end
      r = $urandom_range(0, 99);
      vc = $urandom_range(0, NV - 1);
      if (r < 70 && phase[vc] == 2 && mq[vc].size() > 0) bus.read_i = NV'(1 << vc);
      else if (r == 99) bus.read_i = NV'(1 << vc);
      for (int v = 0; v < NV; v++) begin
        bus.vc_valid_i[v] = ($urandom_range(0, 3) == 0);
        bus.vc_new_i[v]   = VC_SIZE'($urandom);
        bus.out_port_i[v] = port_t'($urandom_range(0, 4));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
